uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

UART byte receiver for the serial-to-SDRAM datapath: takes the asynchronous `rs232_rx` line, oversamples it at 16x the selected baud rate, and recovers 8N1 frames as parallel bytes with a one-cycle `rx_done` strobe. It is the receiving counterpart of the byte transmitter used on the bench. It feeds the write side of the SDRAM controller inside `Sdram_Tx_Rx_Top`.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz; used to derive the baud divider constants.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `baud_set` in 4: baud select.
  - 0 = 9600, 1 = 19200, 2 = 38400, 3 = 57600, 4 = 115200.
  - 5–15 map to 9600.
- `rs232_rx` in 1: serial input, asynchronous to `clk`, idle high.
- `data_byte` out 8: last correctly received byte, LSB first on the line.
- `rx_done` out 1: one-cycle pulse when `data_byte` updates.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `uart_state` out 1: high from start-edge detection until return to IDLE.

## Operation
- Input path:
  - 2-flop synchronizer on `rs232_rx`, plus a 3rd register for edge detection.
  - A falling edge on the synchronized line in IDLE starts a frame.
- Divider values are CLK_FREQ/(baud*16), truncated: 325, 162, 81, 54, 27.
  - The tick counter runs 0..div-1 and emits `tick` at div-1.
  - `baud_set` is latched at start detection; changes mid-frame are ignored.
- Bit timing: each bit is 16 ticks, indexed 0..15.
  - Samples are taken at ticks 7, 8 and 9.
  - The bit value is the 2-of-3 majority.
- States:
  - IDLE → START on falling edge.
  - START: at tick 9, majority 1 (false start) → IDLE, no pulses. Otherwise continue to tick 15 → DATA.
  - DATA: 8 bits, shifted in LSB first. After bit 7 tick 15 → STOP.
  - STOP: at tick 9, majority 1 → `data_byte` updated and `rx_done` pulsed. Majority 0 → `frame_err` pulsed and `data_byte` kept. Either way → IDLE in the same cycle.
- Early return: leaving STOP at tick 9 lets a back-to-back start edge be caught with no gap.
- `rx_done` and `frame_err` are never asserted in the same cycle.
- A line held low after a framing error does not restart a frame; a new frame needs a high-to-low edge.
- Reset mid-frame returns immediately to IDLE with all outputs 0 and the shift register cleared.

## Timing
- Reset values: `data_byte`=0, `rx_done`=0, `frame_err`=0, `uart_state`=0, state=IDLE, counters 0.
- Synchronizer latency is 2 clk; edge detection adds 1 clk.
- At 115200: bit = 432 clk = 8640 ns.
  - `rx_done` asserts ~9.6 bit times after the line's start edge (~82.9 µs), ±1 tick.
- `uart_state` falls in the same cycle as `rx_done` / `frame_err`.
- Sustained back-to-back frames at any supported baud are received without loss.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state sits between DATA and STOP and samples an even-parity bit (9-bit frame).
  - On mismatch, STOP still completes, but `frame_err` pulses instead of `rx_done` and `data_byte` is kept.
- Undefined: 8N1 only; no PARITY state, no parity logic.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - baud divider constants table indexed by `baud_set`;
  - oversample constants (16 ticks per bit, sample ticks 7/8/9).
- One sub-module, `uart_baud_tick`:
  - loadable divider producing the 16x `tick`;
  - cleared at start detection so tick phase aligns to the start edge.

## Test plan
- Reset, then `baud_set`=4 and byte 8'h55 sent 8N1 → one `rx_done` pulse, `data_byte`=8'h55, `frame_err` never high.
- Bytes 8'h01, 8'h02, 8'h03, 8'h04, 8'haa sent back-to-back at 95 µs spacing → five `rx_done` pulses with matching `data_byte` in order.
- 400 ns low glitch on idle line → `uart_state` pulses high, then returns low; no `rx_done`, no `frame_err`.
- Byte 8'hA5 with stop bit forced low → `frame_err` one pulse, `data_byte` retains previous value, no `rx_done`.
- `baud_set`=0, byte 8'h3C at 9600 → `rx_done` with 8'h3C; `baud_set` changed to 4 mid-frame → still received correctly.
- `rst_n` asserted mid-frame at bit 4 → all outputs 0 immediately. After release, next 8'h81 frame received correctly.
  - Run with `UART_RX_PARITY_EN` both defined and undefined; a bad parity bit gives `frame_err`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART byte receiver: FSM states, baud table, 16x oversample indices.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

    localparam int         TICKS_PER_BIT = 16;
    localparam logic [3:0] SAMPLE_A      = 4'd7;
    localparam logic [3:0] SAMPLE_B      = 4'd8;
    localparam logic [3:0] SAMPLE_C      = 4'd9;
    localparam logic [3:0] LAST_TICK     = 4'd15;
    localparam int         DIV_W         = 16;
    localparam int         NUM_BAUDS     = 5;

    // Indexed by baud_set; out-of-range selects fall back to entry 0.
    localparam int BAUD_TBL [NUM_BAUDS] = '{9600, 19200, 38400, 57600, 115200};

    function automatic logic [DIV_W-1:0] calc_div(input int clk_freq, input int baud);
        return DIV_W'(clk_freq / (baud * TICKS_PER_BIT));
    endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Serial-in / byte-out signal bundle of the UART receiver.
interface uart_byte_rx_if;
    logic [3:0] baud_set;
    logic       rs232_rx;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;

    modport master (output baud_set, rs232_rx,
                    input  data_byte, rx_done, frame_err, uart_state);
    modport slave  (input  baud_set, rs232_rx,
                    output data_byte, rx_done, frame_err, uart_state);
endinterface

// File: rtl/uart_baud_tick.sv
// Loadable divider producing the 16x oversample tick; clr realigns phase to the start edge.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == div - DIV_W'(1));
    assign tick = en && !clr && wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || !en || wrap)
            cnt <= '0;
        else
            cnt <= cnt + DIV_W'(1);
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 16x oversampled UART byte receiver (8N1; even parity bit added when UART_RX_PARITY_EN is defined).
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input logic           clk,
    input logic           rst_n,
    uart_byte_rx_if.slave bus
);

    localparam logic [DIV_W-1:0] DIV_TBL [NUM_BAUDS] = '{
        calc_div(CLK_FREQ, BAUD_TBL[0]), calc_div(CLK_FREQ, BAUD_TBL[1]),
        calc_div(CLK_FREQ, BAUD_TBL[2]), calc_div(CLK_FREQ, BAUD_TBL[3]),
        calc_div(CLK_FREQ, BAUD_TBL[4])};

    uart_state_e      state, state_nxt;
    logic             rx_s1, rx_s2, rx_s3;
    logic             fall;
    logic [3:0]       baud_q;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic [3:0]       tick_idx;
    logic [2:0]       bit_cnt;
    logic [1:0]       smp;
    logic             maj;
    logic [7:0]       shreg;
    logic             par_err;
    logic             stop_smp, done_nxt, ferr_nxt;
    logic [7:0]       data_byte_q;
    logic             rx_done_q, frame_err_q;

    // Synchronizer resets to idle-high so release never fakes a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= bus.rs232_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign fall = rx_s3 & ~rx_s2;
    assign maj  = (smp[0] & smp[1]) | (smp[0] & rx_s2) | (smp[1] & rx_s2);

    always_comb begin
        case (baud_q)
            4'd1:    div = DIV_TBL[1];
            4'd2:    div = DIV_TBL[2];
            4'd3:    div = DIV_TBL[3];
            4'd4:    div = DIV_TBL[4];
            default: div = DIV_TBL[0];
        endcase
    end

    uart_baud_tick u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != IDLE),
        .clr   (state == IDLE && fall),
        .div   (div),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stop_smp  = 1'b0;
        done_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            IDLE:
                if (fall) state_nxt = START;
            START:
                if (tick && tick_idx == SAMPLE_C && maj)
                    state_nxt = IDLE;
                else if (tick && tick_idx == LAST_TICK)
                    state_nxt = DATA;
            DATA:
                if (tick && tick_idx == LAST_TICK && bit_cnt == 3'd7)
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
            PARITY:
                if (tick && tick_idx == LAST_TICK)
`endif
                    state_nxt = STOP;
            STOP: begin
                // Leave at mid-bit so a back-to-back start edge is not missed.
                stop_smp = tick && tick_idx == SAMPLE_C;
                done_nxt = stop_smp && maj && !par_err;
                ferr_nxt = stop_smp && !(maj && !par_err);
                if (stop_smp) state_nxt = IDLE;
            end
            default:
                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q      <= '0;
            tick_idx    <= '0;
            bit_cnt     <= '0;
            smp         <= '0;
            shreg       <= '0;
            data_byte_q <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_done_q   <= done_nxt;
            frame_err_q <= ferr_nxt;
            if (done_nxt) data_byte_q <= shreg;
            if (state == IDLE) begin
                tick_idx <= '0;
                bit_cnt  <= '0;
                if (fall) begin
                    baud_q <= bus.baud_set;
                    shreg  <= '0;
                    smp    <= '0;
                end
            end else if (tick) begin
                tick_idx <= tick_idx + 4'd1;
                if (tick_idx == SAMPLE_A) smp[0] <= rx_s2;
                if (tick_idx == SAMPLE_B) smp[1] <= rx_s2;
                if (state == DATA && tick_idx == SAMPLE_C) shreg <= {maj, shreg[7:1]};
                if (state == DATA && tick_idx == LAST_TICK) bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_err <= 1'b0;
        else if (state == IDLE && fall)
            par_err <= 1'b0;
        else if (state == PARITY && tick && tick_idx == SAMPLE_C)
            par_err <= (^shreg) ^ maj;
    end
`else
    assign par_err = 1'b0;
`endif

    assign bus.data_byte  = data_byte_q;
    assign bus.rx_done    = rx_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.uart_state = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: frame-level model pushes expected outcomes, monitor pops on strobes.
module tb_uart_byte_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    uart_byte_rx_if bus();
    uart_byte_rx #(.CLK_FREQ(50_000_000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    typedef struct { bit err; logic [7:0] data; } exp_t;
    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         t_start = 0;
    int         t_done = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int sel);
        int baud;
        case (sel)
            1:       baud = 19200;
            2:       baud = 38400;
            3:       baud = 57600;
            4:       baud = 115200;
            default: baud = 9600;
        endcase
        return 50_000_000 / (baud * 16);
    endfunction

    // Line time of one frame as driven below: full bits plus a 12-tick stop bit.
    function automatic int frame_len(input int div);
        return (16 * (NBITS - 1) + 12) * div;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input bit stop, input bit pflip, input int div);
        logic [10:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^d) ^ pflip;
        bits[10] = stop;
`else
        bits[9] = stop;
`endif
        t_start = cyc;
        for (int i = 0; i < NBITS; i++) begin
            bus.rs232_rx = bits[i];
            repeat ((i == NBITS - 1) ? 12 * div : 16 * div) @(negedge clk);
        end
        bus.rs232_rx = 1'b1;
    endtask

    // Reference outcome: good stop and parity deliver the byte, anything else flags and keeps the old one.
    task automatic send(input logic [7:0] d, input bit stop, input bit pflip, input int div);
        exp_t e;
        bit ok;
        ok = stop;
`ifdef UART_RX_PARITY_EN
        ok = ok && !pflip;
`endif
        if (ok) begin
            e.err = 1'b0; e.data = d; last_good = d;
        end else begin
            e.err = 1'b1; e.data = last_good;
        end
        exp_q.push_back(e);
        drive_frame(d, stop, pflip, div);
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = budget;
        while (exp_q.size() > 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.rx_done || bus.frame_err)) begin
            if (bus.rx_done) t_done = cyc;
            check("done_ferr_exclusive", {31'd0, bus.rx_done & bus.frame_err}, 0);
            check("state_low_on_strobe", {31'd0, bus.uart_state}, 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: rx_done=%0b frame_err=%0b data=%0h, expected none",
                         bus.rx_done, bus.frame_err, bus.data_byte);
            end else begin
                e = exp_q.pop_front();
                check("frame_err_vs_rx_done", {31'd0, bus.frame_err}, {31'd0, e.err});
                check("data_byte", {24'd0, bus.data_byte}, {24'd0, e.data});
            end
        end
    end

    initial begin
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: run did not finish, expected completion within 120000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b [5];
        logic [7:0] d;
        int gw, lat, exp_lat;
        b2b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'haa};

        bus.rs232_rx = 1'b1;
        bus.baud_set = 4'd4;
        repeat (5) @(negedge clk);
        check("rst_data_byte", {24'd0, bus.data_byte}, 0);
        check("rst_rx_done", {31'd0, bus.rx_done}, 0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 0);
        check("rst_uart_state", {31'd0, bus.uart_state}, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 0x55 at 115200, including busy flag and strobe latency
        fork
            send(8'h55, 1'b1, 1'b0, div_of(4));
            begin
                repeat (100) @(negedge clk);
                check("state_busy", {31'd0, bus.uart_state}, 1);
            end
        join
        wait_drain(2000);
        lat = t_done - t_start;
        exp_lat = (96 + 10 * (NBITS - 10)) * 432 / 10;
        check("rx_done_latency_window",
              {31'd0, (lat >= exp_lat - 35) && (lat <= exp_lat + 35)}, 1);

        // back-to-back at 95 us spacing
        for (int i = 0; i < 5; i++) begin
            send(b2b[i], 1'b1, 1'b0, div_of(4));
            if (i < 4) repeat (4750 - frame_len(div_of(4))) @(negedge clk);
        end
        wait_drain(2000);

        // short low glitch: false start only
        gw = $urandom_range(15, 25);
        bus.rs232_rx = 1'b0;
        repeat (gw) @(negedge clk);
        bus.rs232_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("glitch_state_high", {31'd0, bus.uart_state}, 1);
        repeat (400) @(negedge clk);
        check("glitch_state_low", {31'd0, bus.uart_state}, 0);

        // stop bit low: frame error, byte kept
        send(8'ha5, 1'b0, 1'b0, div_of(4));
        wait_drain(2000);
        repeat (50) @(negedge clk);
        check("ferr_keeps_byte", {24'd0, bus.data_byte}, {24'd0, last_good});

`ifdef UART_RX_PARITY_EN
        send(8'h5a, 1'b1, 1'b1, div_of(4));
        wait_drain(2000);
        check("parity_keeps_byte", {24'd0, bus.data_byte}, {24'd0, last_good});
`endif

        // 9600 with baud_set changed mid-frame
        bus.baud_set = 4'd0;
        fork
            send(8'h3c, 1'b1, 1'b0, div_of(0));
            begin
                repeat (3 * 16 * div_of(0)) @(negedge clk);
                bus.baud_set = 4'd4;
            end
        join
        wait_drain(5000);

        // reset in the middle of bit 4 of a random byte
        d = 8'($urandom);
        bus.rs232_rx = 1'b0;
        repeat (16 * div_of(4)) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rs232_rx = d[i];
            repeat (16 * div_of(4)) @(negedge clk);
        end
        bus.rs232_rx = d[4];
        repeat ($urandom_range(50, 350)) @(negedge clk);
        check("pre_rst_busy", {31'd0, bus.uart_state}, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_byte", {24'd0, bus.data_byte}, 0);
        check("mid_rst_rx_done", {31'd0, bus.rx_done}, 0);
        check("mid_rst_frame_err", {31'd0, bus.frame_err}, 0);
        check("mid_rst_uart_state", {31'd0, bus.uart_state}, 0);
        last_good = 8'h00;
        bus.rs232_rx = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send(8'h81, 1'b1, 1'b0, div_of(4));
        wait_drain(2000);

        repeat (20) @(negedge clk);
        check("final_idle", {31'd0, bus.uart_state}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
